dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised, byte-addressable data memory with load/store sizing, byte-lane write enables, and sign/zero extension.
- Has a registered 1-cycle read path, a valid/ready request handshake, misalignment and range error reporting, and an optional zero-fill sweep after reset.
- Sits between the core's execute/memory stage and the data RAM. It replaces the plain word-indexed data memory.

Parameters:
- DATA_W, 32, data word width in bits; legal values 32 or 64.
- DEPTH, 1024, number of DATA_W words; need not be a power of two.
- ADDR_W, 32, byte-address width of addr_i.
- CLEAR_ON_RST, 1, when 1, memory is zero-filled after reset before requests are accepted.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request this cycle.
- wren_i  in  1  1 = store, 0 = load.
- addr_i  in  ADDR_W  byte address.
- size_i  in  2  0 = byte, 1 = half, 2 = word (32b), 3 = dword (legal only when DATA_W = 64).
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- wdata_i  in  DATA_W  store data, right-aligned (the LSBs hold the operand).
- rsp_valid_o  out  1  one-cycle pulse; response for the request accepted in the previous cycle.
- rdata_o  out  DATA_W  load result, extended to DATA_W.
- err_o  out  1  valid with rsp_valid_o; misaligned, out-of-range, or illegal size.

Behaviour:
- Reset and clock: a single clock; reset is synchronous, active-low.
- Reset values, on any clk_i edge with rst_ni = 0:
  - rsp_valid_o = 0, rdata_o = 0, err_o = 0.
  - req_ready_o = 0.
  - FSM goes to CLEAR if CLEAR_ON_RST, else READY.
  - Clear counter = 0.
  - RAM contents are not reset by rst_ni itself.
- Address split:
  - LSB = log2(DATA_W/8); lane = addr_i[LSB-1:0]; word index = addr_i[ADDR_W-1:LSB].
- FSM states:
  - CLEAR: writes 0 to word index = counter each cycle and increments the counter. When counter = DEPTH-1, goes to READY next cycle. req_ready_o = 0.
  - READY: req_ready_o = 1.
  - There are no other states.
- Reset mid-CLEAR: the counter restarts from 0 and the sweep restarts.
- Accept rule:
  - A request is accepted when req_valid_i && req_ready_o.
  - One request is accepted per cycle. Back-to-back acceptance gives full throughput.
  - Requests presented while not ready are ignored; nothing is captured.
- Error conditions, evaluated at accept:
  - Misaligned: lane not a multiple of 2^size_i.
  - Out of range: word index >= DEPTH.
  - Illegal size: size_i = 3 with DATA_W = 32.
  - On error: no RAM write; response has err_o = 1 and rdata_o = 0.
- Store:
  - The RAM write happens at the accept edge, using byte enables for lanes [lane, lane + 2^size_i).
  - Lane data = wdata_i shifted left by lane*8.
  - The response in the next cycle has err_o = 0 and rdata_o = 0.
- Load:
  - The RAM is read synchronously at the accept edge. rsp_valid_o and rdata_o are valid in the next cycle (latency 1).
  - Extraction: selected bytes shifted right by lane*8.
  - Extension: bytes above 2^size_i are 0 if unsigned_i, else copies of the top selected bit.
  - size equal to the full width ignores unsigned_i.
- Hazard: a load in cycle N+1 to the word stored in cycle N returns the new data (the store is already committed). No forwarding logic is required.
- rdata_o and err_o hold their values when rsp_valid_o = 0; only the rsp_valid_o pulse is meaningful.

Decomposition:
- Package dmem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - state_e enum (ST_CLEAR, ST_READY).
  - Function that builds the byte-enable mask from size and lane.
  - Function that extends load data from size and the unsigned flag.
- Sub-module dmem_ram (DATA_W, DEPTH):
  - Single-port synchronous RAM with per-byte write enable and registered read data.
  - Behavioural array only: no reset, inferable as block RAM.
- dmem_lsu contains the FSM, the clear counter, the error check, the lane shift, and the response register.

Test Plan:
- Reset then clear (CLEAR_ON_RST = 1, DEPTH = 1024):
  - Stimulus: hold rst_ni = 0 for 2 cycles, then release.
  - Response: req_ready_o stays 0 for exactly 1024 cycles, then goes to 1.
  - Stimulus: load word at 0x3FC.
  - Response: rdata_o = 0x00000000, err_o = 0.
- Byte stores and sign extension:
  - Stimulus: store word 0x11223344 @0x10; store byte 0xA5 @0x11.
  - Response: load word @0x10 = 0x1122A544; signed byte load @0x11 = 0xFFFFFFA5; unsigned byte load @0x11 = 0x000000A5.
- Half stores:
  - Stimulus: store half 0x8001 @0x22.
  - Response: signed half load @0x22 = 0xFFFF8001; word load @0x20 = 0x8001xxxx, with the low half unchanged from the prior value.
- Misalignment:
  - Stimulus: store word 0xDEADBEEF @0x13.
  - Response: err_o = 1 in the next cycle.
  - Then: load word @0x10 shows the old value, unchanged.
  - Stimulus: half load @0x21.
  - Response: err_o = 1, rdata_o = 0.
- Back-to-back and range:
  - Stimulus: store @0x40 then load @0x40 on consecutive accept cycles.
  - Response: the load returns the new data with 1-cycle latency; rsp_valid_o is high for 2 consecutive cycles.
  - Stimulus: addr = 4*DEPTH.
  - Response: err_o = 1.
- Reset mid-operation:
  - Stimulus: assert rst_ni = 0 at counter = 500 during CLEAR.
  - Response: after release the sweep restarts from 0 and takes 1024 cycles.
  - Stimulus: assert reset the cycle after a load is accepted.
  - Response: rsp_valid_o = 0 with no response.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Byte lanes per word for the widest supported configuration (64-bit).
    localparam int unsigned MAX_BYTES = 8;

    // Byte-enable mask covering lanes [lane, lane + 2^sz); callers slice to their width.
    function automatic logic [MAX_BYTES-1:0] be_mask(input size_e sz, input logic [2:0] lane);
        logic [MAX_BYTES-1:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    // Sign- or zero-extend right-aligned load data of the given size to 64 bits.
    function automatic logic [63:0] load_ext(input logic [63:0] d, input size_e sz,
                                             input logic uns);
        logic [63:0] r;
        case (sz)
            SZ_B:    r = {{56{~uns & d[7]}}, d[7:0]};
            SZ_H:    r = {{48{~uns & d[15]}}, d[15:0]};
            SZ_W:    r = {{32{~uns & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read data.
module dmem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = 10
) (
    input  logic                clk_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic                re_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-masked write and enabled read; no reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we_i[b]) begin
                mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the data RAM: sizing, lane steering, extension, error
// checks, and an optional zero-fill sweep after reset.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_W       = 32,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              wren_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(NB);
    localparam int unsigned IDX_W  = ADDR_W - LSB;
    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q;
    logic [RAM_AW-1:0]   cnt_q;
    logic                ready_q;

    logic [LSB-1:0]      lane;
    logic [IDX_W-1:0]    idx;
    size_e               sz;
    logic                mis, oor, ill, err, accept;
    logic [MAX_BYTES-1:0] be8;

    logic [NB-1:0]       ram_we;
    logic                ram_re;
    logic [RAM_AW-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    logic                rsp_valid_q, err_q, zero_q, uns_q;
    logic [LSB-1:0]      lane_q;
    size_e               sz_q;
    logic [DATA_W-1:0]   rd_shift;
    logic [63:0]         rd_ext;

    // Request decode and error classification.
    always_comb begin
        lane   = addr_i[LSB-1:0];
        idx    = addr_i[ADDR_W-1:LSB];
        sz     = size_e'(size_i);
        // A lane is aligned when its low size_i bits are zero.
        mis    = (3'(lane) & ((3'd1 << size_i) - 3'd1)) != 3'd0;
        oor    = idx >= IDX_W'(DEPTH);
        ill    = (sz == SZ_D) && (DATA_W == 32);
        err    = mis || oor || ill;
        accept = rst_ni && req_valid_i && ready_q;
        be8    = be_mask(sz, 3'(lane));
    end

    // RAM port steering: the clear sweep owns the port until the FSM reaches READY.
    always_comb begin
        ram_we    = '0;
        ram_re    = 1'b0;
        ram_addr  = idx[RAM_AW-1:0];
        ram_wdata = wdata_i << {lane, 3'b000};
        if (state_q == ST_CLEAR) begin
            ram_we    = {NB{rst_ni}};
            ram_addr  = cnt_q;
            ram_wdata = '0;
        end else if (accept && !err) begin
            if (wren_i) ram_we = be8[NB-1:0];
            else        ram_re = 1'b1;
        end
    end

    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Control FSM with clear counter and registered ready.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == RAM_AW'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    // Response metadata captured at accept; it holds until the next accept.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b1;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            sz_q        <= SZ_B;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                err_q  <= err;
                zero_q <= err || wren_i;
                uns_q  <= unsigned_i;
                lane_q <= lane;
                sz_q   <= sz;
            end
        end
    end

    // Lane extraction and extension of the registered RAM word.
    always_comb begin
        rd_shift = ram_rdata >> {lane_q, 3'b000};
        rd_ext   = load_ext(64'(rd_shift), sz_q, uns_q);
        rdata_o  = zero_q ? '0 : rd_ext[DATA_W-1:0];
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, multi-cycle sequences, and random
// traffic checked against a byte-array model of the memory.
module tb_dmem_lsu;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              wren_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [1:0]        size_i = '0;
    logic              unsigned_i = 1'b0;
    logic [DATA_W-1:0] wdata_i = '0;
    logic              req_ready_o, rsp_valid_o, err_o;
    logic [DATA_W-1:0] rdata_o;

    dmem_lsu #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .CLEAR_ON_RST (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .wren_i      (wren_i),
        .addr_i      (addr_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .wdata_i     (wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] mem_m [4*DEPTH];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          err;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4 * DEPTH; i++) mem_m[i] = 8'h00;
    endfunction

    // Byte-addressed reference: stores update bytes, loads assemble little-endian.
    function automatic void model(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                                  input bit u, input logic [31:0] wd,
                                  output logic [31:0] erd, output bit eerr);
        int n = 1 << sz;
        logic [31:0] val;
        eerr = (sz == 2'd3) || (a % n != 0) || (a / 4 >= DEPTH);
        erd  = '0;
        if (!eerr) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
            end else begin
                val = '0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = mem_m[a + i];
                if (!u && n < 4 && val[8*n-1]) begin
                    for (int i = 8 * n; i < 32; i++) val[i] = 1'b1;
                end
                erd = val;
            end
        end
    endfunction

    // One request presented from a falling edge; response sampled on the next falling edge.
    task automatic xact(input bit wr, input logic [31:0] a, input logic [1:0] sz, input bit u,
                        input logic [31:0] wd, output bit v, output logic [31:0] rd,
                        output bit e);
        req_valid_i = 1'b1;
        wren_i      = wr;
        addr_i      = a;
        size_i      = sz;
        unsigned_i  = u;
        wdata_i     = wd;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        v  = rsp_valid_o;
        rd = rdata_o;
        e  = err_o;
    endtask

    task automatic wait_clear(output int cyc, output int rsp);
        cyc = 0;
        rsp = 0;
        while (!req_ready_o && cyc < 3000) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (rsp_valid_o) rsp++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, rsp;
        bit          v, e, eerr;
        logic [31:0] rd, erd;
        bit          wr, u;
        logic [31:0] a, wd;
        logic [1:0]  sz;
        int          r;

        vt.push_back('{1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b1, 32'h010, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 1'b0});
        vt.push_back('{1'b1, 32'h011, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 1'b0});
        vt.push_back('{1'b0, 32'h010, 2'd2, 1'b0, 32'h0, 32'h1122_A544, 1'b0});
        vt.push_back('{1'b0, 32'h011, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFA5, 1'b0});
        vt.push_back('{1'b0, 32'h011, 2'd0, 1'b1, 32'h0, 32'h0000_00A5, 1'b0});
        vt.push_back('{1'b1, 32'h022, 2'd1, 1'b0, 32'h0000_8001, 32'h0, 1'b0});
        vt.push_back('{1'b0, 32'h022, 2'd1, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0});
        vt.push_back('{1'b0, 32'h020, 2'd2, 1'b0, 32'h0, 32'h8001_0000, 1'b0});
        vt.push_back('{1'b1, 32'h013, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1});
        vt.push_back('{1'b0, 32'h010, 2'd2, 1'b0, 32'h0, 32'h1122_A544, 1'b0});
        vt.push_back('{1'b0, 32'h021, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h1000, 2'd2, 1'b0, 32'h5555_5555, 32'h0, 1'b1});
        vt.push_back('{1'b0, 32'h000, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1});
        vt.push_back('{1'b0, 32'h022, 2'd1, 1'b1, 32'h0, 32'h0000_8001, 1'b0});
        vt.push_back('{1'b0, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1});
        vt.push_back('{1'b0, 32'h023, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0});

        // Reset state and first clear sweep.
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        rst_ni = 1'b1;
        wait_clear(cyc, rsp);
        chk("clear_cycles", cyc, 1024);
        model_clear();

        // Reset in the middle of a sweep, with a store held on the bus that must be ignored.
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        req_valid_i = 1'b1;
        wren_i      = 1'b1;
        addr_i      = 32'h0;
        size_i      = 2'd2;
        wdata_i     = 32'hDEAD_BEEF;
        rsp = 0;
        repeat (500) begin
            @(negedge clk_i);
            if (rsp_valid_o || req_ready_o) rsp++;
        end
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("mid_clear_quiet", rsp, 0);
        wait_clear(cyc, rsp);
        req_valid_i = 1'b0;
        chk("reclear_cycles", cyc, 1024);
        chk("reclear_no_rsp", rsp, 0);
        model_clear();
        xact(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, v, rd, e);
        chk("ignored_store_valid", v, 1);
        chk("ignored_store_data", rd, 32'h0);

        // Directed table.
        foreach (vt[i]) begin
            xact(vt[i].wr, vt[i].addr, vt[i].sz, vt[i].uns, vt[i].wd, v, rd, e);
            model(vt[i].wr, vt[i].addr, vt[i].sz, vt[i].uns, vt[i].wd, erd, eerr);
            chk($sformatf("vec%0d_valid", i), v, 1);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("vec%0d_err", i), e, vt[i].err);
        end

        // Store then load to the same word on consecutive accept cycles.
        req_valid_i = 1'b1;
        wren_i      = 1'b1;
        addr_i      = 32'h40;
        size_i      = 2'd2;
        unsigned_i  = 1'b0;
        wdata_i     = 32'hCAFE_F00D;
        @(posedge clk_i);
        #1 wren_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_st_valid", rsp_valid_o, 1);
        chk("b2b_st_err", err_o, 0);
        chk("b2b_st_rdata", rdata_o, 0);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_ld_valid", rsp_valid_o, 1);
        chk("b2b_ld_rdata", rdata_o, 32'hCAFE_F00D);
        chk("b2b_ld_err", err_o, 0);
        model(1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D, erd, eerr);
        @(negedge clk_i);
        chk("b2b_done", rsp_valid_o, 0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r  = $urandom_range(0, 9);
            wr = $urandom_range(0, 1);
            u  = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(4 * DEPTH + $urandom_range(0, 31));
            else if (r < 5)  a = 32'($urandom_range(0, 4 * DEPTH - 1)) & ~32'h3;
            else             a = 32'($urandom_range(0, 127));
            xact(wr, a, sz, u, wd, v, rd, e);
            model(wr, a, sz, u, wd, erd, eerr);
            chk("rnd_valid", v, 1);
            chk($sformatf("rnd_rdata a=%h sz=%0d wr=%0d", a, sz, wr), rd, erd);
            chk($sformatf("rnd_err a=%h sz=%0d", a, sz), e, eerr);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk_i);
                chk("rnd_idle", rsp_valid_o, 0);
            end
        end

        // Reset the cycle after a load is accepted: the response is dropped.
        xact(1'b1, 32'h10, 2'd2, 1'b0, 32'h5A5A_1234, v, rd, e);
        req_valid_i = 1'b1;
        wren_i      = 1'b0;
        addr_i      = 32'h10;
        size_i      = 2'd2;
        @(posedge clk_i);
        #1 begin
            req_valid_i = 1'b0;
            rst_ni      = 1'b0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_after_ld_valid", rsp_valid_o, 0);
        chk("rst_after_ld_rdata", rdata_o, 0);
        chk("rst_after_ld_err", err_o, 0);
        chk("rst_after_ld_ready", req_ready_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
